aes_arbiter: RTL and testbench
==============================

AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, BUSY cycles allowed before the watchdog aborts (used only with AES_ARB_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  out  2  per-requester accept; at most one bit high, for one cycle.
REQ-006 req_plaintext0 / req_plaintext1  in  128 each  per-requester plaintext.
REQ-007 req_key0 / req_key1  in  128 each  per-requester key.
REQ-008 rsp_valid  out  1  response valid.
REQ-009 rsp_ready  in  1  response accept from the consumer.
REQ-010 rsp_id  out  1  requester index of the response.
REQ-011 rsp_data  out  128  ciphertext.
REQ-012 rsp_err  out  1  watchdog abort flag.
REQ-013 core_rst_n  out  1  active-low reset to the AES core.
REQ-014 core_start  out  1  start pulse to the core.
REQ-015 core_plaintext / core_key  out  128 each  registered operands to the core.
REQ-016 core_ciphertext  in  128  core result.
REQ-017 core_done  in  1  core done; sticky until core reset.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, BUSY, RESP and CLEAR.
REQ-019 IDLE: when any req_valid bit is high, grant round-robin (the non-last-granted requester wins a tie), pulse req_ready[grant], latch its plaintext, key and id, and go to LAUNCH.
REQ-020 Latched operands SHALL drive core_plaintext/core_key and stay stable from LAUNCH through CLEAR.
REQ-021 LAUNCH: core_start=1 for exactly one cycle, then go to BUSY.
REQ-022 BUSY: on core_done=1, capture core_ciphertext into rsp_data, set rsp_err=0, and go to RESP.
REQ-023 RESP: hold rsp_valid=1 with rsp_data/rsp_id/rsp_err stable until rsp_ready=1; on that handshake cycle, deassert rsp_valid next cycle and go to CLEAR.
REQ-024 CLEAR: drive core_rst_n=0 for exactly one cycle to rearm the sticky core, then go to IDLE.
REQ-025 The last-granted pointer SHALL update only on the IDLE accept.
REQ-026 Requests arriving outside IDLE SHALL see req_ready=0 and SHALL be neither dropped nor reordered; requesters hold req_valid.
REQ-027 rsp_ready high outside RESP SHALL be ignored.
REQ-028 req_valid deasserting in the accept cycle is not an error; the accept is still final.
REQ-029 Minimum request-to-response latency is 3 cycles plus core latency; back-to-back throughput is one job per (core latency + 4) cycles when rsp_ready is held high.

Reset
REQ-030 While rst=1 at a clock edge: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, core_start=0, core_rst_n=0, core operands=0, last-granted pointer=1 (requester 0 wins first), watchdog counter=0.
REQ-031 core_rst_n SHALL be 1 from the first cycle after rst deasserts, except in CLEAR.
REQ-032 rst mid-job SHALL discard the job with no response and hold the core in reset.

Configuration
REQ-033 With AES_ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to BUSY and increment each BUSY cycle; if it reaches TIMEOUT_CYCLES without core_done, go to RESP with rsp_data=0 and rsp_err=1, then CLEAR as normal.
REQ-034 If core_done and the timeout occur in the same cycle, core_done SHALL win.
REQ-035 Without AES_ARB_TIMEOUT_EN: no counter; rsp_err is tied to 0; BUSY waits indefinitely.

Structure
REQ-036 A shared package aes_arb_pkg SHALL hold the FSM state enum, the AES_W=128 width constant and the requester-count constant (2).
REQ-037 One sub-module, aes_rr_arbiter (2-way round-robin grant with pointer), is natural; the AES core is instantiated outside this block.

Verification
REQ-038 Single request: requester 0 sends key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> rsp_id=0, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0, one core_rst_n low pulse.
REQ-039 Both requesters valid continuously after reset -> grants alternate 0,1,0,1 across four jobs; each rsp_id matches its operands.
REQ-040 rsp_ready held low for 20 cycles in RESP -> rsp_valid/rsp_data stable; no req_ready pulse and no core_start until the handshake.
REQ-041 With AES_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, core model never asserts done -> response after 8 BUSY cycles with rsp_err=1 and rsp_data=0, then IDLE.
REQ-042 rst asserted 5 cycles into BUSY -> no rsp_valid; all outputs at reset values next cycle; the next request is served correctly.

Source files
------------

// File: rtl/aes_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_arb_pkg
// Brief    : Shared widths, requester count and FSM state encoding for the
//            AES request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package aes_arb_pkg;

    localparam int AES_W = 128;
    localparam int N_REQ = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        BUSY   = 3'd2,
        RESP   = 3'd3,
        CLEAR  = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_arbiter_if
// Brief    : Requester, response and AES-core signal bundle. The slave
//            modport is the arbiter's view, master is the environment's.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_arbiter_if;
    import aes_arb_pkg::*;

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    logic [AES_W-1:0] req_plaintext0;
    logic [AES_W-1:0] req_plaintext1;
    logic [AES_W-1:0] req_key0;
    logic [AES_W-1:0] req_key1;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [AES_W-1:0] rsp_data;
    logic             rsp_err;

    logic             core_rst_n;
    logic             core_start;
    logic [AES_W-1:0] core_plaintext;
    logic [AES_W-1:0] core_key;
    logic [AES_W-1:0] core_ciphertext;
    logic             core_done;

    modport slave (
        input  req_valid, req_plaintext0, req_plaintext1, req_key0, req_key1,
        input  rsp_ready, core_ciphertext, core_done,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        output core_rst_n, core_start, core_plaintext, core_key
    );

    modport master (
        output req_valid, req_plaintext0, req_plaintext1, req_key0, req_key1,
        output rsp_ready, core_ciphertext, core_done,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        input  core_rst_n, core_start, core_plaintext, core_key
    );

endinterface
`default_nettype wire

// File: rtl/aes_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_rr_arbiter
// Brief    : Two-way round-robin grant; the pointer remembers the last winner
//            and only moves when the grant is actually accepted.
// Revision : 1.0 - initial release
// ============================================================================
module aes_rr_arbiter
    import aes_arb_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [N_REQ-1:0] req,
    input  wire logic             accept,
    output logic      [N_REQ-1:0] grant,
    output logic                  grant_id
);

    logic r_last;

    // On a tie the requester that did not win last time takes the grant.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_last ? 2'b01 : 2'b10;
        end
    end

    assign grant_id = grant[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (accept && (|req)) begin
            r_last <= grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_arbiter
// Brief    : Shares one external AES core between two requesters; sequences
//            launch, wait, response and a core reset pulse per job.
//            Optional watchdog abort enabled by AES_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aes_arbiter
    import aes_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic    clk,
    input  wire logic    rst,
    aes_arbiter_if.slave bus
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [N_REQ-1:0] w_grant;
    logic             w_grant_id;
    logic             w_accept;
    logic             w_timeout;

    logic [N_REQ-1:0] r_req_ready;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [AES_W-1:0] r_rsp_data;
    logic             r_core_start;
    logic             r_core_rst_n;
    logic [AES_W-1:0] r_core_pt;
    logic [AES_W-1:0] r_core_key;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign w_accept = (r_state == IDLE) && (|bus.req_valid);

    aes_rr_arbiter u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (bus.req_valid),
        .accept   (w_accept),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

`ifdef AES_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_wd_cnt;
    logic               r_rsp_err;

    // Counter sits at zero outside BUSY, so it is clear on every BUSY entry.
    assign w_timeout = (r_state == BUSY) && !bus.core_done &&
                       (r_wd_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || (r_state != BUSY)) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if ((r_state == BUSY) && bus.core_done) begin
            r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign bus.rsp_err = r_rsp_err;
`else
    assign w_timeout   = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|bus.req_valid)                w_state_nxt = LAUNCH;
            LAUNCH:                                     w_state_nxt = BUSY;
            BUSY:    if (bus.core_done || w_timeout)    w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready)                 w_state_nxt = CLEAR;
            CLEAR:                                      w_state_nxt = IDLE;
            default:                                    w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each is a clean
    // per-state level: start during LAUNCH, core reset low during CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_core_start <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_core_pt    <= '0;
            r_core_key   <= '0;
        end else begin
            r_req_ready  <= w_accept ? w_grant : '0;
            r_core_start <= w_accept;
            r_core_rst_n <= (w_state_nxt != CLEAR);
            r_rsp_valid  <= (w_state_nxt == RESP);
            if (w_accept) begin
                r_rsp_id   <= w_grant_id;
                r_core_pt  <= w_grant_id ? bus.req_plaintext1 : bus.req_plaintext0;
                r_core_key <= w_grant_id ? bus.req_key1 : bus.req_key0;
            end
            if (r_state == BUSY) begin
                if (bus.core_done) begin
                    r_rsp_data <= bus.core_ciphertext;
                end else if (w_timeout) begin
                    r_rsp_data <= '0;
                end
            end
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_id         = r_rsp_id;
    assign bus.rsp_data       = r_rsp_data;
    assign bus.core_start     = r_core_start;
    assign bus.core_rst_n     = r_core_rst_n;
    assign bus.core_plaintext = r_core_pt;
    assign bus.core_key       = r_core_key;

endmodule
`default_nettype wire

// File: tb/tb_aes_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_arbiter
// Brief    : Scoreboard bench for aes_arbiter with a behavioural sticky-done
//            AES core model of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_arbiter;
    import aes_arb_pkg::*;

    localparam int TO_CYC = 8;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst;

    aes_arbiter_if bus();

    aes_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [127:0] jpt  [2][16];
    logic [127:0] jkey [2][16];
    int           jn   [2];
    int           jidx [2];

    logic [127:0] sb_data [$];
    logic         sb_id   [$];
    logic         sb_err  [$];

    int   model_last;
    int   resp_cnt;
    int   clr_cnt;
    bit   rsp_seen;
    int   hold_cnt;
    bit   exp_err;
    int   t_accept;
    int   t_rsp;
    bit   prev_rsp_valid;
    logic [3:0] gseq;
    int   gcnt;
    int   base;

    int   core_lat;
    bit   core_hang;

    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ {key[63:0], key[127:64]} ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
    endfunction

    // Behavioural core: done is sticky until core_rst_n is driven low.
    logic         cm_done;
    logic         cm_run;
    logic [127:0] cm_ct;
    int           cm_cnt;

    always @(posedge clk) begin
        if (!bus.core_rst_n) begin
            cm_done <= 1'b0;
            cm_run  <= 1'b0;
            cm_cnt  <= 0;
            cm_ct   <= '0;
        end else if (bus.core_start) begin
            cm_run <= 1'b1;
            cm_cnt <= core_lat - 1;
            cm_ct  <= core_fn(bus.core_plaintext, bus.core_key);
        end else if (cm_run && !core_hang) begin
            if (cm_cnt <= 1) begin
                cm_done <= 1'b1;
                cm_run  <= 1'b0;
            end else begin
                cm_cnt <= cm_cnt - 1;
            end
        end
    end

    assign bus.core_done       = cm_done;
    assign bus.core_ciphertext = cm_done ? cm_ct : 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_job(input int r, input logic [127:0] pt, input logic [127:0] key);
        jpt[r][jn[r]]  = pt;
        jkey[r][jn[r]] = key;
        jn[r]++;
    endtask

    task automatic tick();
        logic [1:0] v;
        int g;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            model_last = 1;
            sb_data.delete();
            sb_id.delete();
            sb_err.delete();
        end else begin
            if (bus.req_ready != 2'b00) begin
                v = bus.req_valid;
                g = (v == 2'b11) ? ((model_last == 1) ? 0 : 1) : (v[1] ? 1 : 0);
                check_eq("grant", 128'(bus.req_ready), (g == 1) ? 128'(2'b10) : 128'(2'b01));
                check_eq("launch_start", 128'(bus.core_start), 128'(1'b1));
                check_eq("launch_pt", bus.core_plaintext, jpt[g][jidx[g] % 16]);
                check_eq("launch_key", bus.core_key, jkey[g][jidx[g] % 16]);
                sb_id.push_back(g[0]);
                sb_err.push_back(exp_err);
                sb_data.push_back(exp_err ? 128'h0 :
                                  core_fn(jpt[g][jidx[g] % 16], jkey[g][jidx[g] % 16]));
                jidx[g]++;
                model_last = g;
                t_accept   = cyc;
                if (gcnt < 4) gseq[gcnt] = g[0];
                gcnt++;
            end
            if (!bus.core_rst_n) clr_cnt++;
            if (bus.rsp_valid && !prev_rsp_valid) t_rsp = cyc;
            if (bus.rsp_valid) rsp_seen = 1'b1;
            if (bus.rsp_valid && hold_cnt > 0) begin
                if (sb_id.size() > 0) begin
                    check_eq("hold_data", bus.rsp_data, sb_data[0]);
                    check_eq("hold_id", 128'(bus.rsp_id), 128'(sb_id[0]));
                end
                check_eq("hold_no_ready", 128'(bus.req_ready), 128'(0));
                check_eq("hold_no_start", 128'(bus.core_start), 128'(0));
                hold_cnt--;
            end
        end
        prev_rsp_valid = bus.rsp_valid;

        bus.req_valid      = {jidx[1] < jn[1], jidx[0] < jn[0]};
        bus.req_plaintext0 = jpt[0][jidx[0] % 16];
        bus.req_key0       = jkey[0][jidx[0] % 16];
        bus.req_plaintext1 = jpt[1][jidx[1] % 16];
        bus.req_key1       = jkey[1][jidx[1] % 16];
        bus.rsp_ready      = (hold_cnt == 0);

        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb_id.size() == 0) begin
                check_eq("rsp_unexpected", 128'(bus.rsp_valid), 128'(0));
            end else begin
                check_eq("rsp_id", 128'(bus.rsp_id), 128'(sb_id.pop_front()));
                check_eq("rsp_data", bus.rsp_data, sb_data.pop_front());
                check_eq("rsp_err", 128'(bus.rsp_err), 128'(sb_err.pop_front()));
            end
            resp_cnt++;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic wait_resp(input int target, input int budget);
        int k;
        k = 0;
        while (resp_cnt < target && k < budget) begin
            tick();
            k++;
        end
        check_eq("resp_count", 128'(resp_cnt), 128'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycles=%0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        rst        = 1'b1;
        jn[0] = 0; jn[1] = 0; jidx[0] = 0; jidx[1] = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 16; k++) begin
                jpt[r][k]  = '0;
                jkey[r][k] = '0;
            end
        end
        model_last = 1; resp_cnt = 0; clr_cnt = 0; rsp_seen = 0; hold_cnt = 0;
        exp_err = 0; t_accept = -1; t_rsp = -1; prev_rsp_valid = 0; gseq = '0; gcnt = 0;
        core_lat = 4; core_hang = 0;
        bus.req_valid = '0; bus.rsp_ready = 1'b1;
        bus.req_plaintext0 = '0; bus.req_plaintext1 = '0; bus.req_key0 = '0; bus.req_key1 = '0;

        // Reset values
        repeat (3) tick();
        check_eq("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check_eq("rst_req_ready", 128'(bus.req_ready), 128'(0));
        check_eq("rst_core_start", 128'(bus.core_start), 128'(0));
        check_eq("rst_core_rst_n", 128'(bus.core_rst_n), 128'(0));
        check_eq("rst_rsp_data", bus.rsp_data, 128'h0);
        check_eq("rst_rsp_id", 128'(bus.rsp_id), 128'(0));
        check_eq("rst_rsp_err", 128'(bus.rsp_err), 128'(0));
        check_eq("rst_core_pt", bus.core_plaintext, 128'h0);
        check_eq("rst_core_key", bus.core_key, 128'h0);
        rst = 1'b0;
        tick();
        check_eq("core_rst_n_release", 128'(bus.core_rst_n), 128'(1));

        // Single FIPS-197 request from requester 0
        clr_cnt = 0;
        add_job(0, FIPS_PT, FIPS_KEY);
        wait_resp(1, 100);
        repeat (3) tick();
        check_eq("clear_pulses", 128'(clr_cnt), 128'(1));

        // Both requesters busy from reset: grants must alternate
        do_reset(2);
        gcnt = 0; gseq = '0; base = resp_cnt;
        for (int k = 0; k < 2; k++) begin
            add_job(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            add_job(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        end
        wait_resp(base + 4, 200);
        check_eq("grant_order", 128'(gseq), 128'(4'b1010));

        // Response back-pressure with another requester waiting
        base = resp_cnt;
        hold_cnt = 21;
        add_job(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        add_job(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        wait_resp(base + 2, 300);
        check_eq("hold_done", 128'(hold_cnt), 128'(0));

        // Reset five cycles into BUSY discards the job
        base = resp_cnt;
        core_lat = 30; rsp_seen = 0; t_accept = -1;
        add_job(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        for (int k = 0; k < 50 && t_accept < 0; k++) tick();
        check_eq("mid_accepted", 128'(jidx[0]), 128'(jn[0]));
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check_eq("mid_core_rst_n", 128'(bus.core_rst_n), 128'(0));
        check_eq("mid_core_start", 128'(bus.core_start), 128'(0));
        check_eq("mid_req_ready", 128'(bus.req_ready), 128'(0));
        check_eq("mid_core_pt", bus.core_plaintext, 128'h0);
        check_eq("mid_rsp_data", bus.rsp_data, 128'h0);
        check_eq("mid_no_response", 128'(rsp_seen), 128'(0));
        core_lat = 4;
        add_job(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        wait_resp(base + 1, 100);

`ifdef AES_ARB_TIMEOUT_EN
        // Watchdog abort with a core that never finishes
        base = resp_cnt;
        core_hang = 1; exp_err = 1; t_accept = -1; t_rsp = -1;
        add_job(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        wait_resp(base + 1, 100);
        check_eq("timeout_latency", 128'(t_rsp - t_accept), 128'(TO_CYC + 1));
        core_hang = 0; exp_err = 0;
        add_job(0, FIPS_PT, FIPS_KEY);
        wait_resp(base + 2, 100);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
